// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch/decode boundary: FSM encoding,
// default two-word marker bit and PC constants shared with the PC unit.
package if_id_stage_pkg;

    typedef enum logic {
        S_OP  = 1'b0,   // expecting an opcode word
        S_IMM = 1'b1    // expecting the immediate of a two-word instruction
    } state_t;

    localparam int          IMM_BIT_DEF = 15;
    localparam logic [31:0] RESET_PC    = 32'h20;
    localparam logic [31:0] INT_VECTOR  = 32'h0;

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between the fetch stage and its neighbours: PC in, instruction
// memory port, pipeline control and the IF/ID register contents.
interface if_id_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pc_in;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               flush;
    logic               INT;
    logic [INSTR_W-1:0] ifid_instr;
    logic [INSTR_W-1:0] ifid_imm;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [ADDR_W-1:0]  ifid_pc_next;
    logic               ifid_valid;
    logic               need_imm;

    // Environment side: PC unit, instruction memory, hazard unit, decode.
    modport master (
        output pc_in, imem_data, stall, flush, INT,
        input  imem_addr, ifid_instr, ifid_imm, ifid_pc, ifid_pc_next,
               ifid_valid, need_imm
    );

    // Fetch stage side.
    modport slave (
        input  pc_in, imem_data, stall, flush, INT,
        output imem_addr, ifid_instr, ifid_imm, ifid_pc, ifid_pc_next,
               ifid_valid, need_imm
    );
endinterface

// File: rtl/if_id_stage_ifid_reg.sv
// IF/ID pipeline register. bubble clears valid and leaves the other fields
// alone (decode ignores them); load captures a complete instruction;
// neither means hold.
module ifid_reg #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bubble,
    input  logic               load,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [INSTR_W-1:0] d_imm,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [ADDR_W-1:0]  d_pc_next,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] imm,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               valid
);

    // Bubble beats load; with neither asserted every field holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr   <= '0;
            imm     <= '0;
            pc      <= '0;
            pc_next <= '0;
            valid   <= 1'b0;
        end else if (bubble) begin
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= d_instr;
            imm     <= d_imm;
            pc      <= d_pc;
            pc_next <= d_pc_next;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch/decode boundary stage. Addresses instruction memory with the
// current PC, stitches two-word instructions together across two cycles
// and feeds the IF/ID register. INT and flush squash, stall freezes.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16,
    parameter int IMM_BIT = IMM_BIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    if_id_stage_if.slave   bus
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [INSTR_W-1:0] hold_word;
    logic [ADDR_W-1:0]  hold_pc;

    logic               kill;
    logic               two_word;
    logic               bubble;
    logic               load;
    logic [INSTR_W-1:0] d_instr;
    logic [INSTR_W-1:0] d_imm;
    logic [ADDR_W-1:0]  d_pc;
    logic [ADDR_W-1:0]  d_pc_next;

    assign bus.imem_addr = bus.pc_in;
    assign bus.need_imm  = (state == S_IMM);

    // Squash sources share one path: both redirect the PC, so flush also
    // overrides stall.
    assign kill     = bus.INT | bus.flush;
    assign two_word = bus.imem_data[IMM_BIT];

    // Enables for the IF/ID register and the instruction being assembled.
    // In S_IMM the opcode and its PC come from the hold registers; the
    // return address always follows the word currently being fetched.
    always_comb begin
        bubble    = kill | (!bus.stall && state == S_OP && two_word);
        load      = !kill && !bus.stall && !(state == S_OP && two_word);
        d_instr   = bus.imem_data;
        d_imm     = '0;
        d_pc      = bus.pc_in;
        d_pc_next = bus.pc_in + ONE;
        if (state == S_IMM) begin
            d_instr = hold_word;
            d_imm   = bus.imem_data;
            d_pc    = hold_pc;
        end
    end

    // Opcode/immediate sequencer; captures the first word of a two-word
    // instruction and drops it when the fetch is squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_OP;
            hold_word <= '0;
            hold_pc   <= '0;
        end else if (kill) begin
            state     <= S_OP;
            hold_word <= '0;
            hold_pc   <= '0;
        end else if (!bus.stall) begin
            case (state)
                S_OP: begin
                    if (two_word) begin
                        hold_word <= bus.imem_data;
                        hold_pc   <= bus.pc_in;
                        state     <= S_IMM;
                    end
                end
                S_IMM:   state <= S_OP;
                default: state <= S_OP;
            endcase
        end
    end

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk       (clk),
        .reset     (reset),
        .bubble    (bubble),
        .load      (load),
        .d_instr   (d_instr),
        .d_imm     (d_imm),
        .d_pc      (d_pc),
        .d_pc_next (d_pc_next),
        .instr     (bus.ifid_instr),
        .imm       (bus.ifid_imm),
        .pc        (bus.ifid_pc),
        .pc_next   (bus.ifid_pc_next),
        .valid     (bus.ifid_valid)
    );

endmodule
